// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory port of the load/store unit: one request channel with a
// valid/ready handshake and one response channel with a valid strobe only.
// The LSU drives the request side and consumes the response side (master).
interface lsu_mem_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_wr;
    logic [3:0]      mem_req_wstrb;
    logic [XLEN-1:0] mem_req_wdata;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_wr,
        output mem_req_wstrb,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_wr,
        input  mem_req_wstrb,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit sitting after decode/control. Issues one word-aligned
// access at a time on the data-memory port, stalls IF/ID/EX while the access
// is in flight and returns sign/zero-extended load data to writeback.
//
// Optional feature: define LSU_TIMEOUT_EN to enable a response watchdog that
// aborts a load with lsu_bus_err after TIMEOUT_CYCLES cycles in RSP. Without
// it, RSP waits indefinitely and lsu_bus_err is tied low.
module lsu_mem_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ex_valid,
    input  logic            ex_data_req,
    input  logic            ex_data_wr,
    input  logic [1:0]      ex_data_byte,
    input  logic            ex_zero_extnd,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wr_data,
    lsu_mem_ctrl_if.master  mem,
    output logic            lsu_stall,
    output logic            lsu_rd_valid,
    output logic [XLEN-1:0] lsu_rd_data,
    output logic            lsu_misaligned,
    output logic            lsu_bus_err
);

    // Lane formatting below is written for a 32-bit datapath only.
    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("lsu_mem_ctrl: XLEN must be 32 and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RSP  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       start;
    logic       misaligned;
    logic       issue;
    logic       mis_fire;
    logic       rsp_take;
    logic       wd_expire;
    logic [1:0] size_r;
    logic [1:0] off_r;
    logic       zext_r;

    // Half must be 2-byte aligned, word 4-byte aligned; double-word is not
    // supported on this 32-bit port and is always rejected.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] f_wstrb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across every lane so the strobes alone
    // select the bytes written.
    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Pick the addressed lane out of the returned word and extend it; the
    // signed size cast provides the sign fill.
    function automatic logic [31:0] f_load_ext(input logic [1:0] size, input logic [1:0] off,
                                               input logic zext, input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: return zext ? {24'b0, b} : 32'(b);
            SZ_HALF: return zext ? {16'b0, h} : 32'(h);
            default: return rdata;
        endcase
    endfunction

    assign start      = (state == S_IDLE) && ex_valid && ex_data_req;
    assign misaligned = f_misaligned(ex_data_byte, ex_addr[1:0]);
    assign lsu_stall  = start || (state == S_REQ) || (state == S_RSP);

    // Next-state and one-cycle action strobes.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        mis_fire  = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        state_nxt = S_DONE;
                        mis_fire  = 1'b1;
                    end else begin
                        state_nxt = S_REQ;
                        issue     = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    state_nxt = mem.mem_req_wr ? S_DONE : S_RSP;
                end
            end
            S_RSP: begin
                if (mem.mem_rsp_valid) begin
                    state_nxt = S_DONE;
                    rsp_take  = 1'b1;
                end else if (wd_expire) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request channel: fields latched at issue and held until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem.mem_req_valid <= 1'b0;
            mem.mem_req_addr  <= '0;
            mem.mem_req_wr    <= 1'b0;
            mem.mem_req_wstrb <= 4'b0000;
            mem.mem_req_wdata <= '0;
        end else if (issue) begin
            mem.mem_req_valid <= 1'b1;
            mem.mem_req_addr  <= {ex_addr[XLEN-1:2], 2'b00};
            mem.mem_req_wr    <= ex_data_wr;
            mem.mem_req_wstrb <= ex_data_wr ? f_wstrb(ex_data_byte, ex_addr[1:0]) : 4'b0000;
            mem.mem_req_wdata <= ex_data_wr ? f_wdata(ex_data_byte, ex_wr_data) : '0;
        end else if (state == S_REQ && mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
        end
    end

    // Access shape kept for load-data extraction in RSP.
    always_ff @(posedge clk) begin
        if (issue) begin
            size_r <= ex_data_byte;
            off_r  <= ex_addr[1:0];
            zext_r <= ex_zero_extnd;
        end
    end

    // Writeback result and completion pulses, all valid during DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lsu_rd_valid   <= 1'b0;
            lsu_rd_data    <= '0;
            lsu_misaligned <= 1'b0;
        end else begin
            lsu_rd_valid   <= rsp_take;
            lsu_misaligned <= mis_fire;
            if (rsp_take) begin
                lsu_rd_data <= f_load_ext(size_r, off_r, zext_r, mem.mem_rsp_rdata);
            end else if (wd_expire) begin
                lsu_rd_data <= '0;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wd_cnt;

    // The limit is hit on the RSP cycle whose increment would take the count
    // to TIMEOUT_CYCLES; a response in that same cycle still wins.
    assign wd_expire = (state == S_RSP) && !mem.mem_rsp_valid &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Response watchdog: cleared entering RSP, counts unanswered RSP cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt      <= '0;
            lsu_bus_err <= 1'b0;
        end else begin
            lsu_bus_err <= wd_expire;
            if (state == S_REQ && state_nxt == S_RSP) begin
                wd_cnt <= '0;
            end else if (state == S_RSP && !mem.mem_rsp_valid) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign lsu_bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized
// transactions, checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
    localparam int XLEN = 32;
    localparam int TO   = 4;
`ifdef LSU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_data_req = 1'b0;
    logic        ex_data_wr = 1'b0;
    logic [1:0]  ex_data_byte = 2'b00;
    logic        ex_zero_extnd = 1'b0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wr_data = '0;
    logic        lsu_stall, lsu_rd_valid, lsu_misaligned, lsu_bus_err;
    logic [31:0] lsu_rd_data;

    lsu_mem_ctrl_if #(.XLEN(XLEN)) mem_bus ();

    lsu_mem_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ex_valid       (ex_valid),
        .ex_data_req    (ex_data_req),
        .ex_data_wr     (ex_data_wr),
        .ex_data_byte   (ex_data_byte),
        .ex_zero_extnd  (ex_zero_extnd),
        .ex_addr        (ex_addr),
        .ex_wr_data     (ex_wr_data),
        .mem            (mem_bus),
        .lsu_stall      (lsu_stall),
        .lsu_rd_valid   (lsu_rd_valid),
        .lsu_rd_data    (lsu_rd_data),
        .lsu_misaligned (lsu_misaligned),
        .lsu_bus_err    (lsu_bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Expected outputs for the current cycle, set by the stimulus process.
    bit          chk_en = 1'b0;
    bit          e_stall, e_req_valid, e_fields, e_wdata_chk, e_rd_chk;
    bit          e_rd_valid, e_mis, e_err, e_wr;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_wstrb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_bytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit m_mis(input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'd3) || ((int'(off) % m_bytes(sz)) != 0);
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 4; k++)
            s[k] = (k >= int'(off)) && (k < int'(off) + m_bytes(sz));
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = wd[8*(k % m_bytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic [1:0] off, input bit zx);
        int bits, sh;
        logic [31:0] mask, v;
        bits = 8 * m_bytes(sz);
        sh   = (sz == 2'd0) ? int'(off) : (sz == 2'd1) ? int'(off & 2'b10) : 0;
        mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        v    = (rd >> (8 * sh)) & mask;
        if (!zx && bits < 32 && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("lsu_stall", 32'(lsu_stall), 32'(e_stall));
            chk("mem_req_valid", 32'(mem_bus.mem_req_valid), 32'(e_req_valid));
            chk("lsu_rd_valid", 32'(lsu_rd_valid), 32'(e_rd_valid));
            chk("lsu_misaligned", 32'(lsu_misaligned), 32'(e_mis));
            chk("lsu_bus_err", 32'(lsu_bus_err), 32'(e_err));
            if (e_fields) begin
                chk("mem_req_addr", mem_bus.mem_req_addr, e_addr);
                chk("mem_req_wr", 32'(mem_bus.mem_req_wr), 32'(e_wr));
                chk("mem_req_wstrb", 32'(mem_bus.mem_req_wstrb), 32'(e_wstrb));
            end
            if (e_wdata_chk) chk("mem_req_wdata", mem_bus.mem_req_wdata, e_wdata);
            if (e_rd_chk)    chk("lsu_rd_data", lsu_rd_data, e_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_stall = 0; e_req_valid = 0; e_fields = 0; e_wdata_chk = 0; e_rd_chk = 0;
        e_rd_valid = 0; e_mis = 0; e_err = 0;
    endtask

    // Every registered output must read zero (used during/after reset).
    task automatic exp_zero();
        exp_idle();
        e_fields = 1; e_addr = '0; e_wr = 0; e_wstrb = '0;
        e_wdata_chk = 1; e_wdata = '0; e_rd_chk = 1; e_rd = '0;
    endtask

    task automatic noise_rsp();
        mem_bus.mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_bus.mem_rsp_rdata = $urandom;
    endtask

    // One complete access, entered and left at #1 after a rising edge.
    task automatic txn(input bit wr, input logic [1:0] sz, input bit zx, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int rdy_dly, input int rsp_dly);
        bit mis, to;
        int n_rsp;
        mis   = m_mis(sz, a[1:0]);
        to    = TO_EN && !wr && !mis && (rsp_dly >= TO);
        n_rsp = to ? TO : rsp_dly + 1;
        // start cycle (IDLE): stall is combinational, memory inputs ignored
        ex_valid = 1; ex_data_req = 1; ex_data_wr = wr; ex_data_byte = sz;
        ex_zero_extnd = zx; ex_addr = a; ex_wr_data = wd;
        mem_bus.mem_req_ready = 1'($urandom_range(0, 1));
        noise_rsp();
        exp_idle(); e_stall = 1;
        step();
        if (!mis) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                exp_idle();
                e_stall = 1; e_req_valid = 1; e_fields = 1;
                e_addr = {a[31:2], 2'b00}; e_wr = wr;
                e_wstrb = wr ? m_wstrb(sz, a[1:0]) : 4'b0000;
                e_wdata_chk = wr; e_wdata = m_wdata(sz, wd);
                mem_bus.mem_req_ready = (i == rdy_dly);
                noise_rsp();
                step();
            end
            mem_bus.mem_req_ready = 1'($urandom_range(0, 1));
            if (!wr) begin
                for (int j = 0; j < n_rsp; j++) begin
                    exp_idle(); e_stall = 1;
                    if (!to && j == rsp_dly) begin
                        mem_bus.mem_rsp_valid = 1; mem_bus.mem_rsp_rdata = rd;
                    end else begin
                        mem_bus.mem_rsp_valid = 0; mem_bus.mem_rsp_rdata = $urandom;
                    end
                    step();
                end
            end
        end
        // DONE: instruction still presented, pulses visible, stall released
        exp_idle();
        e_mis = mis; e_err = to;
        e_rd_valid = !wr && !mis && !to;
        e_rd_chk = e_rd_valid || to;
        e_rd = to ? 32'h0 : m_load(rd, sz, a[1:0], zx);
        noise_rsp();
        step();
        // back in IDLE; the instruction has retired
        ex_valid = 0; ex_data_req = 0;
        noise_rsp();
        exp_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        mem_bus.mem_req_ready = 0;
        mem_bus.mem_rsp_valid = 0;
        mem_bus.mem_rsp_rdata = '0;
        #2 resetn = 0;
        exp_zero();
        chk_en = 1;
        // stale response while held in reset
        mem_bus.mem_rsp_valid = 1;
        step();
        step();
        resetn = 1;
        mem_bus.mem_rsp_valid = 0;
        exp_zero();
        step();

        // model pins (hand-computed)
        chk("pin_lb", m_load(32'h80FF_0000, 2'd0, 2'd3, 1'b0), 32'hFFFF_FF80);
        chk("pin_lhu", m_load(32'hBEEF_1234, 2'd1, 2'd2, 1'b1), 32'h0000_BEEF);
        chk("pin_lh", m_load(32'hBEEF_1234, 2'd1, 2'd2, 1'b0), 32'hFFFF_BEEF);
        chk("pin_sb_wstrb", 32'(m_wstrb(2'd0, 2'd1)), 32'h2);
        chk("pin_sb_wdata", m_wdata(2'd0, 32'h0000_00A5), 32'hA5A5_A5A5);
        chk("pin_sh_wstrb", 32'(m_wstrb(2'd1, 2'd2)), 32'hC);
        chk("pin_mis_lw", 32'(m_mis(2'd2, 2'd2)), 32'h1);
        chk("pin_mis_dw", 32'(m_mis(2'd3, 2'd0)), 32'h1);
        chk("pin_ok_lh", 32'(m_mis(2'd1, 2'd2)), 32'h0);

        // directed cases
        txn(0, 2'd0, 0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);   // LB min latency
        step();
        txn(0, 2'd1, 1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0);   // LHU
        txn(0, 2'd1, 0, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1, 2);   // LH
        step();
        txn(1, 2'd0, 0, 32'h0000_3001, 32'h0000_00A5, 32'h0, 3, 0);   // SB, ready late
        txn(0, 2'd2, 0, 32'h0000_4002, 32'h0, 32'h0, 0, 0);           // LW misaligned
        txn(1, 2'd3, 0, 32'h0000_4000, 32'h1234_5678, 32'h0, 0, 0);   // DW always rejected
        txn(1, 2'd2, 0, 32'h0000_4004, 32'hCAFE_F00D, 32'h0, 0, 0);   // SW
        txn(0, 2'd2, 0, 32'h0000_5000, 32'h0, 32'h1357_9BDF, 0, 20);  // long wait / timeout
        step();

        // reset while a load waits in RSP
        ex_valid = 1; ex_data_req = 1; ex_data_wr = 0; ex_data_byte = 2'd2; ex_addr = 32'h0000_6000;
        mem_bus.mem_rsp_valid = 0;
        exp_idle(); e_stall = 1;
        step();
        mem_bus.mem_req_ready = 1;
        e_req_valid = 1;
        step();
        e_req_valid = 0;
        step();
        resetn = 0;
        ex_valid = 0; ex_data_req = 0;
        exp_zero();
        step();
        resetn = 1;
        mem_bus.mem_rsp_valid = 1; mem_bus.mem_rsp_rdata = 32'hFFFF_FFFF;
        step();
        mem_bus.mem_rsp_valid = 0;
        step();
        exp_idle();

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                ex_valid = 1'($urandom_range(0, 1)); ex_data_req = 0;
                noise_rsp();
                step();
            end
            ex_valid = 0;
        end
        step();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit directly downstream of decode/control.
- Consumes the control_t fields data_req, data_wr, data_byte and zero_extnd, plus the ALU-computed address and store data from execute.
- Issues one word-aligned request at a time on a valid/ready data-memory port and returns sign- or zero-extended load data to the RF writeback mux (MEM source).
- Stalls the pipeline while a memory access is in flight.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, response watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_data_req  in  1  instruction accesses memory (control_t.data_req).
- ex_data_wr  in  1  1=store, 0=load.
- ex_data_byte  in  2  access size: 00 BYTE, 01 HALF_WORD, 10 WORD, 11 DOUBLE_WORD.
- ex_zero_extnd  in  1  load zero-extends when 1, sign-extends when 0.
- ex_addr  in  XLEN  byte address.
- ex_wr_data  in  XLEN  store data (rs2).
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  word-aligned address, i.e. {addr[31:2],2'b00}.
- mem_req_wr  out  1  write request.
- mem_req_wstrb  out  4  byte enables; 0000 for loads.
- mem_req_wdata  out  XLEN  lane-replicated store data.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_rdata  in  XLEN  read word.
- lsu_stall  out  1  hold IF/ID/EX.
- lsu_rd_valid  out  1  one-cycle pulse; lsu_rd_data is valid.
- lsu_rd_data  out  XLEN  extended load result.
- lsu_misaligned  out  1  one-cycle pulse; misaligned or unsupported access.
- lsu_bus_err  out  1  one-cycle pulse; response timeout.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE. All registered outputs are 0: mem_req_valid, mem_req_addr, mem_req_wr, mem_req_wstrb, mem_req_wdata, lsu_rd_valid, lsu_rd_data, lsu_misaligned, lsu_bus_err. Watchdog counter is 0.
- start = state==IDLE & ex_valid & ex_data_req.
- lsu_stall (combinational) = start | state==REQ | state==RSP. It is 0 in DONE and when IDLE with no start.
- Misaligned when any of:
  - HALF_WORD with addr[0]=1;
  - WORD with addr[1:0]!=0;
  - DOUBLE_WORD (always).
- FSM transitions:
  - IDLE, start & misaligned -> DONE; set lsu_misaligned=1; no memory request.
  - IDLE, start & aligned -> REQ; register the request fields; mem_req_valid=1 from the next cycle.
  - REQ: request fields held stable while valid & !ready. On ready: mem_req_valid=0 next cycle; a store goes to DONE, a load goes to RSP.
  - RSP, on mem_rsp_valid: extract and extend the data, register it into lsu_rd_data, set lsu_rd_valid=1, go to DONE.
  - DONE: lasts exactly one cycle; pulse outputs high; ex_* inputs ignored, so the still-held instruction retires without re-issuing; -> IDLE.
- Store lane formatting:
  - BYTE: wdata={4{wd[7:0]}}, wstrb=0001<<addr[1:0].
  - HALF_WORD: wdata={2{wd[15:0]}}, wstrb=0011<<addr[1:0].
  - WORD: wdata=wd, wstrb=1111.
- Load extraction: byte lane addr[1:0], half lane addr[1]. Bits above the accessed width are zero-filled (zero_extnd=1) or sign-filled from the top accessed bit (zero_extnd=0). WORD loads pass through unchanged.
- Minimum latency, counted from the start cycle:
  - ready tied high and a same-cycle response: load pulses lsu_rd_valid 3 cycles after start;
  - store reaches DONE 2 cycles after start.
- mem_rsp_valid in IDLE, REQ or DONE is ignored; this includes a stale response after reset.
- Reset mid-operation: the request is dropped immediately and no pulse is generated.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit or wider counter clears on entry to RSP and increments each RSP cycle without mem_rsp_valid.
  - When the counter reaches TIMEOUT_CYCLES -> DONE with lsu_bus_err=1, lsu_rd_valid=0, lsu_rd_data=0.
  - mem_rsp_valid on the same cycle as the limit takes priority: normal completion, no error.
- Not defined: no counter; RSP waits indefinitely; lsu_bus_err is tied 0.

Test Plan:
- LB, addr=0x1003, rdata=0x80FF_0000, zero_extnd=0 -> wstrb=0000, req addr=0x1000, lsu_rd_data=0xFFFF_FF80, single lsu_rd_valid pulse.
- LHU, addr=0x2002, rdata=0xBEEF_1234 -> lsu_rd_data=0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SB, addr=0x3001, wr_data=0x0000_00A5, ready held low 3 cycles -> wstrb=0010, wdata=0xA5A5_A5A5, request fields stable throughout, lsu_stall high until the ready cycle, DONE reached once.
- LW, addr=0x4002 -> lsu_misaligned pulse, mem_req_valid never asserted, lsu_stall high only in the start cycle; DOUBLE_WORD at 0x4000 -> same.
- Load in RSP, resetn asserted low for 1 cycle, then mem_rsp_valid=1 -> no lsu_rd_valid, state IDLE, all outputs 0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, load never answered -> lsu_bus_err pulse after 4 RSP cycles, lsu_stall drops; without the macro -> lsu_stall stays high.
